action_argmax_stream: RTL and testbench



---
 rtl/ai_act_pkg.sv | 41 ++++
 rtl/action_argmax_stream_top2_tracker.sv | 60 ++++++
 rtl/action_argmax_stream.sv | 121 ++++++++++++
 tb/tb_action_argmax_stream.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ai_act_pkg.sv
// Shared types, action codes and margin helper for the action selection stage.
package ai_act_pkg;

    localparam int N_ACT_DEF = 10;
    localparam int W_DEF     = 16;
    localparam int ACT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    typedef enum logic [ACT_W_DEF-1:0] {
        SHOOT_ENEMY  = 4'd0,
        SHOOT_SELF   = 4'd1,
        MAGNIFIER    = 4'd2,
        BEER         = 4'd3,
        CIGARETTES   = 4'd4,
        HANDCUFFS    = 4'd5,
        HAND_SAW     = 4'd6,
        BURNER_PHONE = 4'd7,
        REVERSE      = 4'd8,
        END_ITEM     = 4'd9
    } action_t;

    localparam logic [ACT_W_DEF-1:0] ACT_NONE = '1;

    // best - second in one extra bit, clipped to the largest positive value of a w-bit field
    function automatic logic [31:0] sat_margin(input logic signed [31:0] best,
                                               input logic signed [31:0] second,
                                               input int w);
        logic signed [32:0] diff;
        logic signed [32:0] lim;
        diff = {best[31], best} - {second[31], second};
        lim  = (33'sd1 <<< (w - 1)) - 33'sd1;
        if (diff > lim) return lim[31:0];
        return diff[31:0];
    endfunction

endpackage

// File: rtl/action_argmax_stream_top2_tracker.sv
// Running best / second-best tracker over a stream of signed logits.
module top2_tracker #(
    parameter int W     = 16,
    parameter int ACT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_beat,
    input  logic signed [W-1:0] i_val,
    input  logic [ACT_W-1:0]    i_idx,
    output logic signed [W-1:0] o_best,
    output logic signed [W-1:0] o_second,
    output logic [ACT_W-1:0]    o_best_idx,
    output logic                o_have_best,
    output logic                o_have_second
);

    logic signed [W-1:0] r_best;
    logic signed [W-1:0] r_second;
    logic [ACT_W-1:0]    r_best_idx;
    logic                r_have_best;
    logic                r_have_second;

    // Strict compares: an equal later logit never displaces the earlier index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best        <= '0;
            r_second      <= '0;
            r_best_idx    <= '0;
            r_have_best   <= 1'b0;
            r_have_second <= 1'b0;
        end else if (i_clear) begin
            r_best        <= '0;
            r_second      <= '0;
            r_best_idx    <= '0;
            r_have_best   <= 1'b0;
            r_have_second <= 1'b0;
        end else if (i_beat) begin
            if (!r_have_best || i_val > r_best) begin
                // NOTE: non-blocking lets the old best shift into second on the same edge.
                r_second      <= r_best;
                r_have_second <= r_have_best;
                r_best        <= i_val;
                r_best_idx    <= i_idx;
                r_have_best   <= 1'b1;
            end else if (!r_have_second || i_val > r_second) begin
                r_second      <= i_val;
                r_have_second <= 1'b1;
            end
        end
    end

    assign o_best        = r_best;
    assign o_second      = r_second;
    assign o_best_idx    = r_best_idx;
    assign o_have_best   = r_have_best;
    assign o_have_second = r_have_second;

endmodule

// File: rtl/action_argmax_stream.sv
// Streaming masked argmax: consumes N_ACT logits per inference and hands the
// winning action, its logit and a confidence margin to the game FSM.
module action_argmax_stream
    import ai_act_pkg::*;
#(
    parameter int N_ACT = N_ACT_DEF,
    parameter int W     = W_DEF,
    parameter int ACT_W = ACT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_ACT-1:0]    mask,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACT_W-1:0]    action,
    output logic signed [W-1:0] best_val,
    output logic signed [W-1:0] margin,
    output logic                none_legal,
    output logic                err
);

    localparam logic [ACT_W-1:0]    NONE_CODE  = '1;
    localparam logic [ACT_W-1:0]    LAST_IDX   = ACT_W'(N_ACT - 1);
    localparam logic signed [W-1:0] MARGIN_MAX = {1'b0, {(W-1){1'b1}}};

    state_t           r_state;
    logic [N_ACT-1:0] r_mask;
    logic [ACT_W-1:0] r_idx;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_err;

    logic                w_clear;
    logic                w_accept;
    logic                w_at_last;
    logic                w_final;
    logic                w_legal_beat;
    logic                w_have_result;
    logic signed [W-1:0] w_best;
    logic signed [W-1:0] w_second;
    logic [ACT_W-1:0]    w_best_idx;
    logic                w_have_best;
    logic                w_have_second;

    // An abort wins over a beat presented on the same cycle; that beat is dropped.
    assign w_clear      = start && (r_state != DONE);
    assign w_accept     = in_valid && r_in_ready && !start;
    assign w_at_last    = (r_idx == LAST_IDX);
    assign w_final      = w_accept && (in_last || w_at_last);
    assign w_legal_beat = w_accept && r_mask[r_idx];

    top2_tracker #(.W(W), .ACT_W(ACT_W)) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (w_clear),
        .i_beat        (w_legal_beat),
        .i_val         (in_data),
        .i_idx         (r_idx),
        .o_best        (w_best),
        .o_second      (w_second),
        .o_best_idx    (w_best_idx),
        .o_have_best   (w_have_best),
        .o_have_second (w_have_second)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state    <= ACCUM;
                    r_mask     <= mask;
                    r_idx      <= '0;
                    r_err      <= 1'b0;
                    r_in_ready <= 1'b1;
                end
                ACCUM: if (start) begin
                    r_mask <= mask;
                    r_idx  <= '0;
                    r_err  <= 1'b0;
                end else if (w_final) begin
                    r_state     <= DONE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_err       <= (in_last != w_at_last);
                end else if (w_accept) begin
                    r_idx <= r_idx + 1'b1;
                end
                DONE: if (out_ready) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tracker registers are frozen in DONE, so these decodes are stable for the whole handshake.
    assign w_have_result = r_out_valid && w_have_best;
    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign action        = w_have_result ? w_best_idx : NONE_CODE;
    assign best_val      = w_have_result ? w_best : '0;
    assign none_legal    = r_out_valid && !w_have_best;
    assign err           = r_out_valid && r_err;
    assign margin        = !w_have_result ? '0 :
                           w_have_second  ? W'(sat_margin(32'(w_best), 32'(w_second), W)) :
                                            MARGIN_MAX;

endmodule

// File: tb/tb_action_argmax_stream.sv
// Bench for action_argmax_stream: directed cases plus randomized inferences
// checked against a two-pass argmax reference model.
module tb_action_argmax_stream;

    localparam int N = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [N-1:0]        mask;
    logic                in_valid;
    logic                in_ready;
    logic signed [15:0]  in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [3:0]          action;
    logic signed [15:0]  best_val;
    logic signed [15:0]  margin;
    logic                none_legal;
    logic                err;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] lg [N];
    bit                 early_valid, lat_valid, got_valid, stable_ok;
    bit                 post_valid, post_ready;
    logic [3:0]         post_action;
    logic [3:0]         exp_action;
    logic signed [15:0] exp_best, exp_margin;
    bit                 exp_none, exp_err;

    action_argmax_stream #(.N_ACT(N), .W(16), .ACT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mask       (mask),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .action     (action),
        .best_val   (best_val),
        .margin     (margin),
        .none_legal (none_legal),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // Reference: pick the first maximum among legal beats, then the maximum of the remaining legal beats.
    task automatic model(input logic [N-1:0] m, input int nb, input int last_pos);
        int bi, sv, d;
        bit sf;
        bi = -1; sf = 0; sv = 0;
        for (int i = 0; i < nb; i++)
            if (m[i] && (bi < 0 || int'(lg[i]) > int'(lg[bi]))) bi = i;
        for (int i = 0; i < nb; i++)
            if (m[i] && i != bi && (!sf || int'(lg[i]) > sv)) begin sf = 1; sv = int'(lg[i]); end
        if (bi < 0) begin
            exp_action = 4'hF; exp_best = '0; exp_margin = '0; exp_none = 1;
        end else begin
            exp_action = 4'(bi); exp_best = lg[bi]; exp_none = 0;
            if (!sf) exp_margin = 16'sd32767;
            else begin
                d = int'(lg[bi]) - sv;
                exp_margin = (d > 32767) ? 16'sd32767 : 16'(d);
            end
        end
        exp_err = (last_pos != N - 1);
    endtask

    task automatic stream(input logic [N-1:0] m, input int last_pos, input bit gaps, input bit do_start);
        int f, w;
        f = (last_pos >= 0 && last_pos < N) ? last_pos : N - 1;
        early_valid = 0;
        if (do_start) begin
            @(negedge clk); start = 1; mask = m;
            @(negedge clk); start = 0;
        end
        for (int b = 0; b <= f; b++) begin
            if (gaps) begin
                in_valid = 0; in_last = 0;
                @(negedge clk);
                if (out_valid) early_valid = 1;
            end
            w = 0;
            while (in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            in_valid = 1; in_data = lg[b]; in_last = (b == last_pos);
            @(negedge clk);
            if (b < f && out_valid) early_valid = 1;
        end
        in_valid = 0; in_last = 0;
        lat_valid = out_valid;
        w = 0;
        while (out_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        got_valid = (out_valid === 1'b1);
    endtask

    task automatic handshake(input int stall, input bit poke_start);
        logic [3:0] a;
        logic signed [15:0] bv, mg;
        logic nl, e;
        a = action; bv = best_val; mg = margin; nl = none_legal; e = err;
        stable_ok = 1;
        for (int i = 0; i < stall; i++) begin
            if (poke_start && i == 1) begin start = 1; mask = '1; end
            else start = 0;
            @(negedge clk);
            if (out_valid !== 1'b1 || action !== a || best_val !== bv || margin !== mg ||
                none_legal !== nl || err !== e) stable_ok = 0;
        end
        start = 0; out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        post_valid = out_valid; post_action = action; post_ready = in_ready;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (action !== 4'hF) begin errors++; $display("FAIL reset_action got %0d want 15", action); end
        checks++; if (best_val !== 16'sd0 || margin !== 16'sd0) begin errors++; $display("FAIL reset_vals got best %0d margin %0d want 0 0", best_val, margin); end
        checks++; if (none_legal !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags got none %b err %b want 0 0", none_legal, err); end
        @(negedge clk); rst = 0;
        @(negedge clk);
    endtask

    task automatic test_all_legal;
        lg = '{-5, 3, 7, 2, 7, 0, -1, 1, 4, 6};
        stream(10'h3FF, 9, 0, 1);
        checks++; if (!lat_valid || early_valid) begin errors++; $display("FAIL t1_latency got lat %b early %b want 1 0", lat_valid, early_valid); end
        checks++; if (action !== 4'd2) begin errors++; $display("FAIL t1_action got %0d want 2", action); end
        checks++; if (best_val !== 16'sd7) begin errors++; $display("FAIL t1_best got %0d want 7", best_val); end
        checks++; if (margin !== 16'sd0) begin errors++; $display("FAIL t1_margin got %0d want 0", margin); end
        checks++; if (err !== 1'b0 || none_legal !== 1'b0) begin errors++; $display("FAIL t1_flags got err %b none %b want 0 0", err, none_legal); end
        handshake(0, 0);
        checks++; if (post_valid !== 1'b0 || post_action !== 4'hF) begin errors++; $display("FAIL t1_release got valid %b action %0d want 0 15", post_valid, post_action); end
    endtask

    task automatic test_single_legal;
        lg = '{default: 16'sd100};
        lg[1] = -16'sd2000;
        stream(10'b0000000010, 9, 0, 1);
        checks++; if (action !== 4'd1) begin errors++; $display("FAIL t2_action got %0d want 1", action); end
        checks++; if (best_val !== -16'sd2000) begin errors++; $display("FAIL t2_best got %0d want -2000", best_val); end
        checks++; if (margin !== 16'sd32767) begin errors++; $display("FAIL t2_margin got %0d want 32767", margin); end
        checks++; if (none_legal !== 1'b0) begin errors++; $display("FAIL t2_none got %b want 0", none_legal); end
        handshake(0, 0);
    endtask

    task automatic test_none_legal;
        lg = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        stream(10'h000, 9, 0, 1);
        checks++; if (!lat_valid) begin errors++; $display("FAIL t3_valid got %b want 1", lat_valid); end
        checks++; if (action !== 4'hF) begin errors++; $display("FAIL t3_action got %0d want 15", action); end
        checks++; if (none_legal !== 1'b1) begin errors++; $display("FAIL t3_none got %b want 1", none_legal); end
        checks++; if (margin !== 16'sd0 || best_val !== 16'sd0) begin errors++; $display("FAIL t3_vals got margin %0d best %0d want 0 0", margin, best_val); end
        handshake(0, 0);
    endtask

    task automatic test_stall;
        lg = '{-5, 3, 7, 2, 7, 0, -1, 1, 4, 6};
        stream(10'h3FF, 9, 1, 1);
        checks++; if (!lat_valid || early_valid) begin errors++; $display("FAIL t4_latency got lat %b early %b want 1 0", lat_valid, early_valid); end
        checks++; if (action !== 4'd2 || best_val !== 16'sd7 || margin !== 16'sd0 || err !== 1'b0) begin
            errors++; $display("FAIL t4_result got %0d/%0d/%0d/%b want 2/7/0/0", action, best_val, margin, err); end
        handshake(5, 1);
        checks++; if (!stable_ok) begin errors++; $display("FAIL t4_stable got changing outputs want stable"); end
        checks++; if (post_valid !== 1'b0 || post_ready !== 1'b0 || post_action !== 4'hF) begin
            errors++; $display("FAIL t4_idle got valid %b ready %b action %0d want 0 0 15", post_valid, post_ready, post_action); end
    endtask

    task automatic test_last_mismatch;
        lg = '{1, 2, 3, 9, 0, 0, 0, 50, 60, 70};
        stream(10'h3FF, 6, 0, 1);
        checks++; if (!lat_valid) begin errors++; $display("FAIL t5a_latency got %b want 1", lat_valid); end
        checks++; if (action !== 4'd3 || margin !== 16'sd6) begin errors++; $display("FAIL t5a_result got action %0d margin %0d want 3 6", action, margin); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t5a_err got %b want 1", err); end
        handshake(0, 0);
        lg = '{-5, 3, 7, 2, 7, 0, -1, 1, 4, 6};
        stream(10'h3FF, -1, 0, 1);
        checks++; if (!lat_valid || action !== 4'd2) begin errors++; $display("FAIL t5b_result got valid %b action %0d want 1 2", lat_valid, action); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t5b_err got %b want 1", err); end
        handshake(0, 0);
    endtask

    task automatic test_restart;
        lg = '{default: 16'sd1000};
        lg[8] = 16'sd50; lg[9] = -16'sd7;
        @(negedge clk); start = 1; mask = '1;
        @(negedge clk); start = 0;
        for (int b = 0; b < 4; b++) begin
            in_valid = 1; in_data = 16'sd30000; in_last = 0;
            @(negedge clk);
        end
        in_valid = 0; start = 1; mask = 10'b1100000000;
        @(negedge clk); start = 0;
        stream(10'b1100000000, 9, 0, 0);
        checks++; if (!lat_valid || early_valid) begin errors++; $display("FAIL t6a_latency got lat %b early %b want 1 0", lat_valid, early_valid); end
        checks++; if (action !== 4'd8 || best_val !== 16'sd50) begin errors++; $display("FAIL t6a_result got action %0d best %0d want 8 50", action, best_val); end
        checks++; if (margin !== 16'sd57 || err !== 1'b0) begin errors++; $display("FAIL t6a_margin got margin %0d err %b want 57 0", margin, err); end
        handshake(0, 0);
    endtask

    task automatic test_async_reset;
        lg = '{-5, 3, 7, 2, 7, 0, -1, 1, 4, 6};
        stream(10'h3FF, 9, 0, 1);
        #2 rst = 1;
        #1;
        checks++; if (out_valid !== 1'b0 || action !== 4'hF || best_val !== 16'sd0) begin
            errors++; $display("FAIL t6b_done_reset got valid %b action %0d best %0d want 0 15 0", out_valid, action, best_val); end
        @(negedge clk); rst = 0;
        @(negedge clk); start = 1; mask = '1;
        @(negedge clk); start = 0;
        in_valid = 1; in_data = 16'sd12; in_last = 0;
        @(negedge clk);
        @(negedge clk);
        in_valid = 0;
        #2 rst = 1;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL t6b_accum_reset got ready %b valid %b want 0 0", in_ready, out_valid); end
        @(negedge clk); rst = 0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t6b_idle got ready %b want 0", in_ready); end
    endtask

    task automatic test_random;
        logic [N-1:0] m;
        int lp, st, f;
        bit g;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       m = '1;
                1:       m = N'($urandom);
                2:       m = N'(1 << $urandom_range(0, N - 1));
                default: m = N'($urandom) & N'($urandom);
            endcase
            for (int i = 0; i < N; i++)
                lg[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(int'($urandom_range(0, 6)) - 3);
            lp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N)) - 1 : N - 1;
            g  = 1'($urandom_range(0, 1));
            st = int'($urandom_range(0, 3));
            f  = (lp >= 0) ? lp : N - 1;
            model(m, f + 1, lp);
            stream(m, lp, g, 1);
            checks++; if (!got_valid || !lat_valid || early_valid) begin
                errors++; $display("FAIL rnd%0d_latency got valid %b lat %b early %b want 1 1 0", it, got_valid, lat_valid, early_valid); end
            checks++; if (action !== exp_action) begin errors++; $display("FAIL rnd%0d_action got %0d want %0d", it, action, exp_action); end
            checks++; if (best_val !== exp_best) begin errors++; $display("FAIL rnd%0d_best got %0d want %0d", it, best_val, exp_best); end
            checks++; if (margin !== exp_margin) begin errors++; $display("FAIL rnd%0d_margin got %0d want %0d", it, margin, exp_margin); end
            checks++; if (none_legal !== exp_none || err !== exp_err) begin
                errors++; $display("FAIL rnd%0d_flags got none %b err %b want %b %b", it, none_legal, err, exp_none, exp_err); end
            handshake(st, 0);
            checks++; if (!stable_ok || post_valid !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_handshake got stable %b valid %b want 1 0", it, stable_ok, post_valid); end
        end
    endtask

    initial begin
        rst = 1; start = 0; mask = '0; in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
        test_reset;
        test_all_legal;
        test_single_legal;
        test_none_legal;
        test_stall;
        test_last_mismatch;
        test_restart;
        test_async_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
